sprite_line_scheduler: RTL
==========================

# sprite_line_scheduler

Per-scanline sprite scheduler that feeds sprite register words, one at a time, to the print pipeline's `data_reg` input. The CPU writes a double-buffered sprite register bank. At each line start the block scans every slot, builds an ordered list of sprites that intersect the next line, and hands the list to the printer through a valid/next handshake. It sits between the CPU register interface and the full print pipeline, on the pipeline's clock.

## Interface
Parameters:
- `NUM_SLOTS`, 32, number of sprite registers.
- `SLOT_BITS`, 5, log2 of `NUM_SLOTS`.
- `MAX_PER_LINE`, 8, maximum sprites listed per line.
- `LIST_BITS`, 4, width of the count output, which holds 0..`MAX_PER_LINE`.
- `SPRITE_H`, 20, sprite height in lines.
- `size_y`, 10, line coordinate width.

Ports:
- `clk`  input  1  the single clock; everything is clocked on its rising edge.
- `reset`  input  1  synchronous, active-low reset.
- `frame_start`  input  1  one-cycle pulse; copies the shadow bank into the active bank.
- `line_start`  input  1  one-cycle pulse; starts a scan for `line_y`.
- `line_y`  input  `size_y`  line to schedule; sampled when `line_start` is high.
- `wr_en`  input  1  CPU write strobe.
- `wr_addr`  input  `SLOT_BITS`  shadow slot index.
- `wr_data`  input  32  sprite word: [31] enable, [28:19] x, [18:9] y, [8:0] memory offset.
- `next`  input  1  printer consumes the current `data_reg`.
- `data_reg`  output  32  current list entry, or 0 when the list is empty.
- `data_valid`  output  1  `data_reg` holds a list entry.
- `busy`  output  1  scan in progress.
- `line_count`  output  `LIST_BITS`  number of entries in the completed list.
- `overflow`  output  1  the last scan found more than `MAX_PER_LINE` hits.

## Operation
Reset, while `reset` is 0:
- Both banks cleared to 0.
- State is IDLE.
- All outputs are 0.
- The list is emptied.

CPU writes:
- `wr_en` writes `wr_data` to `shadow[wr_addr]` every cycle, in any state.
- Writes never touch the active bank directly.

Frame copy:
- `frame_start` copies the whole shadow bank to the active bank in one cycle, in any state.
- A write in the same cycle lands in shadow after the copy, so it becomes visible at the next frame.

State machine: IDLE, SCAN, READY.
- IDLE → SCAN on `line_start`.
  - Latch `line_y`.
  - Clear the list, `line_count`, `overflow` and `data_valid`.
  - Set the slot index to 0.
- SCAN examines one active slot per cycle, index 0 to `NUM_SLOTS`-1.
  - Hit: enable=1 and (`line_y` − y), computed mod 2^`size_y`, is less than `SPRITE_H`.
  - A hit is appended if fewer than `MAX_PER_LINE` entries are stored; otherwise it sets `overflow`.
  - The list stays in ascending slot order.
  - After the last slot: go to READY and publish `line_count`.
- READY presents list entry 0 with `data_valid`=1 if the count is greater than 0.
  - Each cycle with `next`=1 and `data_valid`=1 advances to the next entry.
  - After the last entry: `data_valid`=0 and `data_reg`=0.
  - `next` while `data_valid`=0 is ignored.
- `line_start` in SCAN or READY aborts the current work and restarts SCAN with the new `line_y`. The old list is discarded.
- If `frame_start` and `line_start` coincide, the scan reads the freshly copied active bank: the copy takes effect before slot 0 is examined.
- Wrap-around: the modulo subtraction lets sprites with y near 2^`size_y`−1 hit lines 0.. correctly.

## Timing
- `line_start` at cycle T: `busy`=1 from T+1 through T+`NUM_SLOTS`.
- First `data_valid` at T+`NUM_SLOTS`+1, which is 33 cycles with the defaults.
- `line_count` and `overflow` are valid from that same cycle and hold until the next `line_start`.
- `next` at cycle C: the new `data_reg` appears at C+1. Throughput is one entry per cycle.
- All outputs are registered; there is no combinational path from input to output.
- Reset in mid-scan or mid-list returns the block to IDLE on the next edge with all outputs 0. Both banks clear.

## Structure
- Shared package `sprite_pkg`:
  - Sprite-word field positions (enable, x, y, offset).
  - State encoding IDLE/SCAN/READY.
  - Default `NUM_SLOTS`, `MAX_PER_LINE`, `SPRITE_H`.
- One natural sub-module, `sprite_hit_check`, combinational: takes a sprite word, `line_y` and `SPRITE_H`, and returns a hit bit.
- The banks, list storage, pointers and FSM live in the top level.

## Test plan
- Reset mid-scan: assert `reset`=0 at scan cycle 10 → next cycle `busy`=0, `data_valid`=0, `line_count`=0; a later `line_start` scans an all-zero bank → `line_count`=0.
- Basic list: write slots 3, 7, 12 with enable=1 and y=100, then `frame_start`, then `line_start` with `line_y`=105.
  - `data_valid` rises 33 cycles after `line_start`; `line_count`=3.
  - With `next` held high, `data_reg` returns slot 3, slot 7, slot 12, then 0 with `data_valid`=0.
- Range edges: sprite y=100.
  - `line_y`=119 → hit.
  - `line_y`=120 → no hit.
  - `line_y`=99 → no hit.
  - Sprite y=1020 with `line_y`=5 → hit (wrap-around).
- Overflow: 10 enabled sprites at y=0, `line_y`=0 → `line_count`=8, `overflow`=1, and the list holds the 8 lowest slot indices.
- Double buffer: write slot 0 without `frame_start` → scan misses it. Issue `frame_start` and a `wr_en` to slot 1 in the same cycle → slot 0 hits, slot 1 does not until the next `frame_start`.
- Abort: `line_start` at scan cycle 15 with a new `line_y` → the list reflects only the new line; `data_valid` rises 33 cycles after the second pulse.

Source files
------------

// File: rtl/sprite_pkg.sv
// Shared definitions for the per-scanline sprite scheduler:
// sprite-word field positions, FSM encoding and default sizes.
package sprite_pkg;

    localparam int NUM_SLOTS_D    = 32;
    localparam int MAX_PER_LINE_D = 8;
    localparam int SPRITE_H_D     = 20;

    localparam int EN_BIT  = 31;
    localparam int X_MSB   = 28;
    localparam int X_LSB   = 19;
    localparam int Y_MSB   = 18;
    localparam int Y_LSB   = 9;
    localparam int OFS_MSB = 8;
    localparam int OFS_LSB = 0;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        READY
    } state_t;

endpackage

// File: rtl/sprite_line_if.sv
// CPU write port, line/frame strobes and printer handshake
// of the sprite line scheduler.
interface sprite_line_if #(
    parameter int SLOT_BITS = 5,
    parameter int LIST_BITS = 4,
    parameter int size_y    = 10
);
    logic                 frame_start;
    logic                 line_start;
    logic [size_y-1:0]    line_y;
    logic                 wr_en;
    logic [SLOT_BITS-1:0] wr_addr;
    logic [31:0]          wr_data;
    logic                 next;
    logic [31:0]          data_reg;
    logic                 data_valid;
    logic                 busy;
    logic [LIST_BITS-1:0] line_count;
    logic                 overflow;

    modport master (
        output frame_start, line_start, line_y,
        output wr_en, wr_addr, wr_data, next,
        input  data_reg, data_valid, busy,
        input  line_count, overflow
    );

    modport slave (
        input  frame_start, line_start, line_y,
        input  wr_en, wr_addr, wr_data, next,
        output data_reg, data_valid, busy,
        output line_count, overflow
    );
endinterface

// File: rtl/sprite_hit_check.sv
// Combinational test: does an enabled sprite cover line_y?
// Modulo subtraction handles sprites straddling the wrap.
module sprite_hit_check
    import sprite_pkg::*;
#(
    parameter int size_y   = 10,
    parameter int SPRITE_H = SPRITE_H_D
) (
    input  logic [31:0]       word,
    input  logic [size_y-1:0] line_y,
    output logic              hit
);
    logic [size_y-1:0] dy;

    assign dy  = line_y - word[Y_LSB +: size_y];
    assign hit = word[EN_BIT] && (int'(dy) < SPRITE_H);
endmodule

// File: rtl/sprite_line_scheduler.sv
// Double-buffered sprite bank scanned once per line into an
// ordered hit list, streamed to the printer via valid/next.
module sprite_line_scheduler
    import sprite_pkg::*;
#(
    parameter int NUM_SLOTS    = NUM_SLOTS_D,
    parameter int SLOT_BITS    = 5,
    parameter int MAX_PER_LINE = MAX_PER_LINE_D,
    parameter int LIST_BITS    = 4,
    parameter int SPRITE_H     = SPRITE_H_D,
    parameter int size_y       = 10
) (
    input logic     clk,
    input logic     reset,
    sprite_line_if.slave bus
);
    localparam int IW = $clog2(MAX_PER_LINE);

    logic [31:0]          shadow [NUM_SLOTS];
    logic [31:0]          active [NUM_SLOTS];
    logic [31:0]          list   [MAX_PER_LINE];
    logic [SLOT_BITS-1:0] idx;
    logic [LIST_BITS-1:0] cnt, cnt_n, ptr, ptr_n;
    logic [size_y-1:0]    ly;
    logic [31:0]          cur, first;
    logic                 hit, full, last, ovf;
    state_t               state, state_n;

    assign cur   = active[idx];
    assign last  = idx == SLOT_BITS'(NUM_SLOTS - 1);
    assign full  = cnt == LIST_BITS'(MAX_PER_LINE);
    assign cnt_n = cnt + LIST_BITS'(hit && !full);
    assign ptr_n = ptr + LIST_BITS'(1);
    // a hit on the final slot is not in list[] yet when we publish
    assign first = (cnt == '0) ? cur : list[0];

    sprite_hit_check #(
        .size_y   (size_y),
        .SPRITE_H (SPRITE_H)
    ) u_hit (
        .word   (cur),
        .line_y (ly),
        .hit    (hit)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
                shadow[i] <= '0;
                active[i] <= '0;
            end
        end else begin
            if (bus.frame_start)
                for (int i = 0; i < NUM_SLOTS; i++)
                    active[i] <= shadow[i];
            if (bus.wr_en)
                shadow[bus.wr_addr] <= bus.wr_data;
        end
    end

    always_comb begin
        state_n = state;
        if (bus.line_start)
            state_n = SCAN;
        else if (state == SCAN && last)
            state_n = READY;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state          <= IDLE;
            idx            <= '0;
            cnt            <= '0;
            ptr            <= '0;
            ly             <= '0;
            ovf            <= 1'b0;
            bus.busy       <= 1'b0;
            bus.data_valid <= 1'b0;
            bus.data_reg   <= '0;
            bus.line_count <= '0;
            bus.overflow   <= 1'b0;
            for (int i = 0; i < MAX_PER_LINE; i++)
                list[i] <= '0;
        end else begin
            state <= state_n;
            if (bus.line_start) begin
                ly             <= bus.line_y;
                idx            <= '0;
                cnt            <= '0;
                ptr            <= '0;
                ovf            <= 1'b0;
                bus.busy       <= 1'b1;
                bus.data_valid <= 1'b0;
                bus.data_reg   <= '0;
                bus.line_count <= '0;
                bus.overflow   <= 1'b0;
            end else begin
                case (state)
                    SCAN: begin
                        idx <= idx + SLOT_BITS'(1);
                        if (hit && !full) begin
                            list[cnt[IW-1:0]] <= cur;
                            cnt <= cnt_n;
                        end
                        if (hit && full)
                            ovf <= 1'b1;
                        if (last) begin
                            bus.busy       <= 1'b0;
                            bus.line_count <= cnt_n;
                            bus.overflow   <= ovf || (hit && full);
                            bus.data_valid <= cnt_n != '0;
                            bus.data_reg   <= (cnt_n != '0) ? first : '0;
                        end
                    end
                    READY: begin
                        if (bus.next && bus.data_valid) begin
                            ptr <= ptr_n;
                            if (ptr_n < cnt) begin
                                bus.data_reg <= list[ptr_n[IW-1:0]];
                            end else begin
                                bus.data_valid <= 1'b0;
                                bus.data_reg   <= '0;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule
